// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM states, funct3 codes,
// lsb_op field layout and the access-size decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    IOWAIT = 2'd3
  } state_t;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // lsb_op = {valid, is_store, funct3[2:0]}
  localparam int OP_VALID = 4;
  localparam int OP_STORE = 3;
  localparam int OP_F3_HI = 2;
  localparam int OP_F3_LO = 0;

  // addr[17:16] value that selects the IO region
  localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

  // Bytes moved for a given funct3; unused codes behave like a word.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b100: size_of = 3'd1;
      3'b001, 3'b101: size_of = 3'd2;
      default:        size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Sign/zero extension of a little-endian load result according to funct3.
module mem_ctrl_extend
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Pick the extension rule; words and unused codes pass through.
  always_comb begin
    case (funct3)
      F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  ext = {24'h0, raw[7:0]};
      F3_LHU:  ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller shared by the load/store buffer and the
// instruction fetch unit. One transaction at a time; LSB has priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_TAG = IO_TAG_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic [4:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic [1:0]  lsb_ready,
  output logic [31:0] lsb_mem_data,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  size_q, size_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        fetch_q, fetch_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] wdata_q, wdata_d;

  logic [1:0]  lsb_ready_d;
  logic [31:0] lsb_mem_data_d;
  logic        if_done_d;
  logic [31:0] if_data_d;
  logic [7:0]  mem_dout_d;
  logic [31:0] mem_a_d;
  logic        mem_wr_d;

  logic [2:0]  cnt_nxt;
  logic [31:0] cap_word;
  logic [31:0] ext_word;
  logic [2:0]  lsb_funct3;

  assign cnt_nxt    = cnt_q + 3'd1;
  assign lsb_funct3 = lsb_op[OP_F3_HI:OP_F3_LO];

  // Read buffer with the byte arriving this cycle merged in at the current slot.
  always_comb begin
    cap_word = rbuf_q;
    cap_word[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
  end

  mem_ctrl_extend u_extend (
    .funct3 (funct3_q),
    .raw    (cap_word),
    .ext    (ext_word)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    base_d         = base_q;
    size_d         = size_q;
    funct3_d       = funct3_q;
    fetch_d        = fetch_q;
    cnt_d          = cnt_q;
    rbuf_d         = rbuf_q;
    wdata_d        = wdata_q;
    lsb_ready_d    = {1'b0, lsb_ready[0]};
    lsb_mem_data_d = lsb_mem_data;
    if_done_d      = 1'b0;
    if_data_d      = if_data;
    mem_dout_d     = mem_dout;
    mem_a_d        = mem_a;
    mem_wr_d       = mem_wr;

    case (state_q)
      IDLE: begin
        if (lsb_op[OP_VALID] && !flush) begin
          base_d         = lsb_addr;
          size_d         = size_of(lsb_funct3);
          funct3_d       = lsb_funct3;
          fetch_d        = 1'b0;
          cnt_d          = 3'd0;
          rbuf_d         = 32'h0;
          mem_a_d        = lsb_addr;
          lsb_ready_d[0] = 1'b0;
          if (lsb_op[OP_STORE]) begin
            wdata_d    = lsb_data;
            mem_dout_d = lsb_data[7:0];
            if (lsb_addr[17:16] == IO_TAG && io_buffer_full) begin
              state_d  = IOWAIT;
              mem_wr_d = 1'b0;
            end else begin
              state_d  = WRITE;
              mem_wr_d = 1'b1;
            end
          end else begin
            state_d = READ;
          end
        end else if (if_req && !flush) begin
          base_d         = if_addr;
          size_d         = 3'd4;
          funct3_d       = F3_LW;
          fetch_d        = 1'b1;
          cnt_d          = 3'd0;
          rbuf_d         = 32'h0;
          mem_a_d        = if_addr;
          lsb_ready_d[0] = 1'b0;
          state_d        = READ;
        end
      end

      READ: begin
        if (flush) begin
          // Speculative read is dropped without a completion pulse.
          state_d        = IDLE;
          mem_a_d        = 32'h0;
          lsb_ready_d[0] = 1'b1;
        end else begin
          rbuf_d = cap_word;
          if (cnt_nxt == size_q) begin
            state_d        = IDLE;
            mem_a_d        = 32'h0;
            lsb_ready_d[0] = 1'b1;
            if (fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = cap_word;
            end else begin
              lsb_ready_d[1] = 1'b1;
              lsb_mem_data_d = ext_word;
            end
          end else begin
            cnt_d   = cnt_nxt;
            mem_a_d = base_q + 32'(cnt_nxt);
          end
        end
      end

      WRITE: begin
        // Stores are committed at ROB head, so flush does not stop them.
        if (cnt_nxt == size_q) begin
          state_d        = IDLE;
          mem_wr_d       = 1'b0;
          mem_a_d        = 32'h0;
          mem_dout_d     = 8'h0;
          lsb_ready_d    = 2'b11;
          lsb_mem_data_d = 32'h0;
        end else begin
          cnt_d      = cnt_nxt;
          mem_a_d    = base_q + 32'(cnt_nxt);
          mem_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
        end
      end

      IOWAIT: begin
        // Address and first byte are already on the bus; just enable the write.
        if (!io_buffer_full) begin
          state_d  = WRITE;
          mem_wr_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; rst clears everything, rdy=0 freezes it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= 32'h0;
      size_q       <= 3'd0;
      funct3_q     <= 3'd0;
      fetch_q      <= 1'b0;
      cnt_q        <= 3'd0;
      rbuf_q       <= 32'h0;
      wdata_q      <= 32'h0;
      lsb_ready    <= 2'b01;
      lsb_mem_data <= 32'h0;
      if_done      <= 1'b0;
      if_data      <= 32'h0;
      mem_dout     <= 8'h0;
      mem_a        <= 32'h0;
      mem_wr       <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      base_q       <= base_d;
      size_q       <= size_d;
      funct3_q     <= funct3_d;
      fetch_q      <= fetch_d;
      cnt_q        <= cnt_d;
      rbuf_q       <= rbuf_d;
      wdata_q      <= wdata_d;
      lsb_ready    <= lsb_ready_d;
      lsb_mem_data <= lsb_mem_data_d;
      if_done      <= if_done_d;
      if_data      <= if_data_d;
      mem_dout     <= mem_dout_d;
      mem_a        <= mem_a_d;
      mem_wr       <= mem_wr_d;
    end
  end

endmodule
